// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: IF stage with fetch PC, 1-entry skid buffer and redirect drain
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h00000000,
  parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        BRANCH_TAKEN,
  input  logic [31:0] BRANCH_TARGET,
  input  logic        STALL,
  output logic [31:0] IMEM_ADDR,
  output logic        IMEM_READ,
  input  logic [31:0] IMEM_READDATA,
  input  logic        IMEM_BUSYWAIT,
  output logic [31:0] INSTRUCTION,
  output logic [31:0] PC_OUT,
  output logic [31:0] PC_PLUS4,
  output logic        INSTR_VALID,
  output logic        IF_BUSYWAIT
);
  localparam logic [1:0] FETCH = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0]  state;
  logic [31:0] pc;
  logic [31:0] buf_data;
  logic [31:0] buf_pc;
  logic        buf_valid;
  logic [31:0] drain_addr;
  logic        active;
  logic        done;
  // A read is outstanding whenever we are not parked in HOLD; reset silences the bus
  assign active      = !RESET && state != HOLD;
  assign done        = active && !IMEM_BUSYWAIT;
  assign IMEM_READ   = active;
  assign IMEM_ADDR   = state == DRAIN ? drain_addr : pc;
  assign IF_BUSYWAIT = active && IMEM_BUSYWAIT;
  assign PC_PLUS4    = PC_OUT + 32'd4;
  // PC, skid buffer, IF/ID register and fetch state machine
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      buf_data    <= '0;
      buf_pc      <= '0;
      buf_valid   <= 1'b0;
      drain_addr  <= '0;
      INSTRUCTION <= NOP_INSTR;
      PC_OUT      <= '0;
      INSTR_VALID <= 1'b0;
    end else if (BRANCH_TAKEN) begin
      // The in-flight address is latched so the memory sees a stable request until it completes
      pc          <= BRANCH_TARGET & ~32'd3;
      drain_addr  <= IMEM_ADDR;
      state       <= active && IMEM_BUSYWAIT ? DRAIN : FETCH;
      buf_valid   <= 1'b0;
      INSTRUCTION <= NOP_INSTR;
      INSTR_VALID <= 1'b0;
    end else begin
      case (state)
        FETCH: if (done) begin
          pc <= pc + 32'd4;
          if (STALL) begin
            buf_data  <= IMEM_READDATA;
            buf_pc    <= pc;
            buf_valid <= 1'b1;
            state     <= HOLD;
          end else begin
            INSTRUCTION <= IMEM_READDATA;
            PC_OUT      <= pc;
            INSTR_VALID <= 1'b1;
          end
        end
        HOLD: if (!STALL && buf_valid) begin
          INSTRUCTION <= buf_data;
          PC_OUT      <= buf_pc;
          INSTR_VALID <= 1'b1;
          buf_valid   <= 1'b0;
          state       <= FETCH;
        end
        DRAIN: if (done) state <= FETCH;
        default: state <= FETCH;
      endcase
    end
  end
endmodule
